beu_issue: RTL and testbench
============================

// Module: beu_issue
// PURPOSE
//  Issue stage directly upstream of the bit-manip execution unit (beu). Decodes RV32 Zba/Zbb/Zbs instruction words into
//  the beu function code, operand pair and ALU compare control, and presents them through a 2-entry skid buffer.
//  The skid buffer gives full throughput with a registered ready. Non-Zb* words raise an illegal flag.
// PARAMETERS
//  none (feature selection by macro only)
// PORTS
//  s_clk_i         in   1   clock
//  s_resetn_i      in   1   synchronous reset, active-low
//  s_flush_i       in   1   drop all buffered entries (pipeline kill)
//  s_valid_i       in   1   upstream entry valid
//  s_ready_o       out  1   buffer can accept; registered
//  s_instr_i       in   32  RV32 instruction word
//  s_rs1_i         in   32  rs1 value
//  s_rs2_i         in   32  rs2 value
//  s_valid_o       out  1   entry at head valid
//  s_ready_i       in   1   beu/execute accepts head
//  s_function_o    out  f_part  beu function code (p_hardisc)
//  s_op1_o         out  32  operand 1 (= rs1)
//  s_op2_o         out  32  operand 2: rs2, zero-extended shamt, or MISC selector
//  s_cmp_op_o      out  2   {unsigned, max} control to ALU comparator (MINMAX only, else 2'b00)
//  s_illegal_o     out  1   word is not a supported Zb* instruction; function = BEU_XNOR, operands passed through
// BEHAVIOUR
//  Reset (s_resetn_i=0 at clk edge): both entries invalid, s_valid_o=0, s_ready_o=1, data outputs 0.
//  Transfer: in when s_valid_i&s_ready_o; out when s_valid_o&s_ready_i. Decode is combinational before the buffer.
//  Latency: 1 cycle input->s_valid_o when empty. Throughput 1/cycle with s_ready_i held high.
//  States: EMPTY (head invalid), ONE (head valid), FULL (head+skid valid). s_ready_o = (state!=FULL), registered.
//   EMPTY: in -> ONE. ONE: in&out -> ONE; in&!out -> FULL; out&!in -> EMPTY.
//   FULL: out -> ONE, skid moves to head same edge; no input accepted (ready=0).
//  Order strictly FIFO; head outputs stable while s_valid_o&!s_ready_i.
//  s_flush_i: next edge -> EMPTY, ready=1; a simultaneous input is dropped. Reset has priority over flush.
//  Decode (opcode OP=0110011 / OP-IMM=0010011):
//   sh1/2/3add -> BEU_SH1/2/3ADD, op2=rs2. andn/orn/xnor -> BEU_ANDN/ORN/XNOR. rol/ror -> BEU_ROL/ROR.
//   bset/bclr/binv/bext -> BEU_BSET/BCLR/BINV/BEXT; imm forms (bseti.., rori) op2={27'b0,instr[24:20]}.
//   min/minu/max/maxu -> BEU_MINMAX, s_cmp_op_o={funct3[0],funct3[1]}; ALU asserts compare when result must be rs2.
//   clz/ctz/cpop/sext.b/sext.h/orc.b/rev8 -> BEU_MISC, op2={20'b0,instr[31:20]}; BEU_I_* equal those imm12 values.
//   zext.h (OP, funct7=0000100, rs2=0, funct3=100) -> BEU_MISC, op2=BEU_I_ZEXTH.
//   imm shift with instr[25]=1 (shamt>31) -> illegal.
// CONFIGURATION
//  HARDISC_ZBC_EN defined: clmul (funct7=0000101, funct3=001) -> BEU_CLMUL, op2=rs2; clmulh/clmulr -> illegal.
//  Undefined: every funct7=0000101 word -> illegal; BEU_CLMUL never issued.
// STRUCTURE
//  p_hardisc: BEU_I_* constants, beu_cmp_t (2-bit), beu_issue_t struct {function, op1, op2, cmp_op, illegal}.
//  Sub-module beu_decoder: pure combinational instr/rs1/rs2 -> beu_issue_t; buffer is two beu_issue_t regs + valids.
// TESTING
//  sh2add, rs1=0x10, rs2=0x3 -> 1 cycle later BEU_SH2ADD, op1=0x10, op2=0x3, illegal=0.
//  clz x1 (0x60009093) -> BEU_MISC, op2=0x600; cpop -> op2=0x602; zext.h (0x0800C0B3) -> op2=BEU_I_ZEXTH.
//  maxu -> BEU_MINMAX, cmp_op=2'b11; min -> 2'b00; add (0x002080B3) -> illegal=1.
//  3 back-to-back inputs, s_ready_i=0 -> ready_o drops after 2nd; release -> order 1,2,3, no loss/dup.
//  FULL then s_flush_i with s_valid_i=1 -> next cycle s_valid_o=0, s_ready_o=1, input dropped.
//  clmul with/without HARDISC_ZBC_EN -> BEU_CLMUL illegal=0 / illegal=1; bseti shamt=40 -> illegal.

Source files
------------

// File: rtl/beu_issue_pkg.sv
// Shared types and constants for the bit-manip issue stage (package p_hardisc).
package p_hardisc;

    localparam int unsigned F_PART = 4;

    // beu function codes
    typedef enum logic [F_PART-1:0] {
        BEU_SH1ADD = 4'd0,
        BEU_SH2ADD = 4'd1,
        BEU_SH3ADD = 4'd2,
        BEU_ANDN   = 4'd3,
        BEU_ORN    = 4'd4,
        BEU_XNOR   = 4'd5,
        BEU_ROL    = 4'd6,
        BEU_ROR    = 4'd7,
        BEU_BSET   = 4'd8,
        BEU_BCLR   = 4'd9,
        BEU_BINV   = 4'd10,
        BEU_BEXT   = 4'd11,
        BEU_MINMAX = 4'd12,
        BEU_MISC   = 4'd13,
        BEU_CLMUL  = 4'd14
    } beu_func_t;

    // MISC selectors: the imm12 field of the unary instructions
    localparam logic [11:0] BEU_I_CLZ   = 12'h600;
    localparam logic [11:0] BEU_I_CTZ   = 12'h601;
    localparam logic [11:0] BEU_I_CPOP  = 12'h602;
    localparam logic [11:0] BEU_I_SEXTB = 12'h604;
    localparam logic [11:0] BEU_I_SEXTH = 12'h605;
    localparam logic [11:0] BEU_I_ORCB  = 12'h287;
    localparam logic [11:0] BEU_I_REV8  = 12'h698;
    // zext.h is an OP-format word; its selector is {funct7, rs2} = 0x080
    localparam logic [11:0] BEU_I_ZEXTH = 12'h080;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

    // {unsigned, max}
    typedef logic [1:0] beu_cmp_t;

    typedef struct packed {
        beu_func_t   func;
        logic [31:0] op1;
        logic [31:0] op2;
        beu_cmp_t    cmp_op;
        logic        illegal;
    } beu_issue_t;

endpackage

// File: rtl/beu_issue_decoder.sv
// Combinational Zba/Zbb/Zbs (optionally Zbc clmul) decoder into a beu_issue_t.
// Macro HARDISC_ZBC_EN enables clmul decode.
module beu_issue_decoder
    import p_hardisc::*;
(
    input  logic [31:0] instr_i,
    input  logic [31:0] rs1_i,
    input  logic [31:0] rs2_i,
    output beu_issue_t  issue_o
);

    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [11:0] imm12;
    logic [31:0] shamt;
    logic        legal;
    beu_func_t   func;
    logic [31:0] op2;
    beu_cmp_t    cmp;
    logic        unused_rd;

    assign opc       = instr_i[6:0];
    assign f3        = instr_i[14:12];
    assign f7        = instr_i[31:25];
    assign imm12     = instr_i[31:20];
    assign shamt     = {27'b0, instr_i[24:20]};
    assign unused_rd = ^instr_i[11:7];

    // Decode; anything not matched stays illegal with operands passed through
    always_comb begin
        legal = 1'b0;
        func  = BEU_XNOR;
        op2   = rs2_i;
        cmp   = 2'b00;
        if (opc == OPC_OP) begin
            case (f7)
                7'b0010000: begin
                    legal = 1'b1;
                    case (f3)
                        3'b010:  func = BEU_SH1ADD;
                        3'b100:  func = BEU_SH2ADD;
                        3'b110:  func = BEU_SH3ADD;
                        default: legal = 1'b0;
                    endcase
                end
                7'b0100000: begin
                    legal = 1'b1;
                    case (f3)
                        3'b111:  func = BEU_ANDN;
                        3'b110:  func = BEU_ORN;
                        3'b100:  func = BEU_XNOR;
                        default: legal = 1'b0;
                    endcase
                end
                7'b0110000: begin
                    legal = 1'b1;
                    case (f3)
                        3'b001:  func = BEU_ROL;
                        3'b101:  func = BEU_ROR;
                        default: legal = 1'b0;
                    endcase
                end
                7'b0010100: if (f3 == 3'b001) begin
                    legal = 1'b1;
                    func  = BEU_BSET;
                end
                7'b0100100: begin
                    legal = 1'b1;
                    case (f3)
                        3'b001:  func = BEU_BCLR;
                        3'b101:  func = BEU_BEXT;
                        default: legal = 1'b0;
                    endcase
                end
                7'b0110100: if (f3 == 3'b001) begin
                    legal = 1'b1;
                    func  = BEU_BINV;
                end
                7'b0000101: begin
                    if (f3[2]) begin
                        legal = 1'b1;
                        func  = BEU_MINMAX;
                        cmp   = {f3[0], f3[1]};
                    end
`ifdef HARDISC_ZBC_EN
                    else if (f3 == 3'b001) begin
                        legal = 1'b1;
                        func  = BEU_CLMUL;
                    end
`endif
                end
                7'b0000100: if (f3 == 3'b100 && instr_i[24:20] == 5'd0) begin
                    legal = 1'b1;
                    func  = BEU_MISC;
                    op2   = {20'b0, BEU_I_ZEXTH};
                end
                default: legal = 1'b0;
            endcase
        end else if (opc == OPC_OP_IMM) begin
            if (f3 == 3'b001) begin
                if (imm12 == BEU_I_CLZ || imm12 == BEU_I_CTZ || imm12 == BEU_I_CPOP ||
                    imm12 == BEU_I_SEXTB || imm12 == BEU_I_SEXTH) begin
                    legal = 1'b1;
                    func  = BEU_MISC;
                    op2   = {20'b0, imm12};
                end else if (!instr_i[25]) begin
                    // instr[25] set would be a shamt above 31
                    op2   = shamt;
                    legal = 1'b1;
                    case (instr_i[31:26])
                        6'b001010: func = BEU_BSET;
                        6'b010010: func = BEU_BCLR;
                        6'b011010: func = BEU_BINV;
                        default: begin
                            legal = 1'b0;
                            op2   = rs2_i;
                        end
                    endcase
                end
            end else if (f3 == 3'b101) begin
                if (imm12 == BEU_I_ORCB || imm12 == BEU_I_REV8) begin
                    legal = 1'b1;
                    func  = BEU_MISC;
                    op2   = {20'b0, imm12};
                end else if (!instr_i[25]) begin
                    op2   = shamt;
                    legal = 1'b1;
                    case (instr_i[31:26])
                        6'b010010: func = BEU_BEXT;
                        6'b011000: func = BEU_ROR;
                        default: begin
                            legal = 1'b0;
                            op2   = rs2_i;
                        end
                    endcase
                end
            end
        end
    end

    // Assemble the issue record
    always_comb begin
        issue_o.func    = func;
        issue_o.op1     = rs1_i;
        issue_o.op2     = op2;
        issue_o.cmp_op  = cmp;
        issue_o.illegal = ~legal;
    end

endmodule

// File: rtl/beu_issue.sv
// Bit-manip issue stage: decoder followed by a 2-entry skid buffer with registered ready.
// Macro HARDISC_ZBC_EN enables clmul issue (handled in the decoder).
module beu_issue
    import p_hardisc::*;
(
    input  logic        s_clk_i,
    input  logic        s_resetn_i,
    input  logic        s_flush_i,
    input  logic        s_valid_i,
    output logic        s_ready_o,
    input  logic [31:0] s_instr_i,
    input  logic [31:0] s_rs1_i,
    input  logic [31:0] s_rs2_i,
    output logic        s_valid_o,
    input  logic        s_ready_i,
    output beu_func_t   s_function_o,
    output logic [31:0] s_op1_o,
    output logic [31:0] s_op2_o,
    output beu_cmp_t    s_cmp_op_o,
    output logic        s_illegal_o
);

    typedef enum logic [1:0] {StEmpty, StOne, StFull} state_e;

    state_e     state_q, state_d;
    beu_issue_t head_q, head_d;
    beu_issue_t skid_q, skid_d;
    logic       ready_q, ready_d;
    beu_issue_t dec;
    logic       in_fire;
    logic       out_fire;

    beu_issue_decoder u_decoder (
        .instr_i (s_instr_i),
        .rs1_i   (s_rs1_i),
        .rs2_i   (s_rs2_i),
        .issue_o (dec)
    );

    assign in_fire  = s_valid_i & ready_q;
    assign out_fire = (state_q != StEmpty) & s_ready_i;

    // Next-state and buffer data movement
    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        skid_d  = skid_q;
        if (s_flush_i) begin
            state_d = StEmpty;
        end else begin
            unique case (state_q)
                StEmpty: if (in_fire) begin
                    head_d  = dec;
                    state_d = StOne;
                end
                StOne: begin
                    if (in_fire && out_fire) begin
                        head_d = dec;
                    end else if (in_fire) begin
                        skid_d  = dec;
                        state_d = StFull;
                    end else if (out_fire) begin
                        state_d = StEmpty;
                    end
                end
                StFull: if (out_fire) begin
                    head_d  = skid_q;
                    state_d = StOne;
                end
                default: state_d = StEmpty;
            endcase
        end
        ready_d = (state_d != StFull);
    end

    // State, ready and buffer registers
    always_ff @(posedge s_clk_i) begin
        if (!s_resetn_i) begin
            state_q <= StEmpty;
            ready_q <= 1'b1;
            head_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
            head_q  <= head_d;
            skid_q  <= skid_d;
        end
    end

    assign s_ready_o    = ready_q;
    assign s_valid_o    = (state_q != StEmpty);
    assign s_function_o = head_q.func;
    assign s_op1_o      = head_q.op1;
    assign s_op2_o      = head_q.op2;
    assign s_cmp_op_o   = head_q.cmp_op;
    assign s_illegal_o  = head_q.illegal;

endmodule

// File: tb/tb_beu_issue.sv
// Directed bench for beu_issue: decode table plus skid-buffer and flush sequences.
module tb_beu_issue;
    import p_hardisc::*;

    logic        clk;
    logic        resetn;
    logic        flush;
    logic        valid_i;
    logic        ready_o;
    logic [31:0] instr;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        valid_o;
    logic        ready_i;
    beu_func_t   func_o;
    logic [31:0] op1_o;
    logic [31:0] op2_o;
    beu_cmp_t    cmp_o;
    logic        ill_o;

    int checks = 0;
    int errors = 0;

    beu_issue dut (
        .s_clk_i      (clk),
        .s_resetn_i   (resetn),
        .s_flush_i    (flush),
        .s_valid_i    (valid_i),
        .s_ready_o    (ready_o),
        .s_instr_i    (instr),
        .s_rs1_i      (rs1),
        .s_rs2_i      (rs2),
        .s_valid_o    (valid_o),
        .s_ready_i    (ready_i),
        .s_function_o (func_o),
        .s_op1_o      (op1_o),
        .s_op2_o      (op2_o),
        .s_cmp_op_o   (cmp_o),
        .s_illegal_o  (ill_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] rs1;
        logic [31:0] rs2;
        beu_func_t   func;
        logic [31:0] op2;
        logic [1:0]  cmp;
        logic        ill;
    } vec_t;

    vec_t vecs[16];

    function automatic logic [31:0] rtype(input logic [6:0] f7, input logic [2:0] f3);
        return {f7, 5'd2, 5'd1, f3, 5'd3, 7'b0110011};
    endfunction

    function automatic logic [31:0] itype(input logic [11:0] imm, input logic [2:0] f3);
        return {imm, 5'd1, f3, 5'd3, 7'b0010011};
    endfunction

    task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Sample packing: {valid, ready, illegal, cmp, func, op1, op2}
    function automatic logic [95:0] pack_out();
        return {23'b0, valid_o, ready_o, ill_o, cmp_o, func_o, op1_o, op2_o};
    endfunction

    function automatic logic [95:0] pack_exp(input logic v, input logic r, input logic il,
                                             input logic [1:0] c, input beu_func_t f,
                                             input logic [31:0] a, input logic [31:0] b);
        return {23'b0, v, r, il, c, f, a, b};
    endfunction

    logic [31:0] popped[$];
    int          sent;

    initial begin
        // rs1/rs2 per vector chosen so op2 from rs2 differs from imm-derived op2
        vecs[0]  = '{rtype(7'b0010000, 3'b100), 32'h10, 32'h3, BEU_SH2ADD, 32'h3, 2'b00, 1'b0};
        vecs[1]  = '{32'h60009093, 32'h11, 32'hAA, BEU_MISC, 32'h600, 2'b00, 1'b0};
        vecs[2]  = '{32'h60209093, 32'h12, 32'hAB, BEU_MISC, 32'h602, 2'b00, 1'b0};
        vecs[3]  = '{32'h0800C0B3, 32'h13, 32'hAC, BEU_MISC, 32'h080, 2'b00, 1'b0};
        vecs[4]  = '{rtype(7'b0000101, 3'b111), 32'h14, 32'h55, BEU_MINMAX, 32'h55, 2'b11, 1'b0};
        vecs[5]  = '{rtype(7'b0000101, 3'b100), 32'h15, 32'h56, BEU_MINMAX, 32'h56, 2'b00, 1'b0};
        vecs[6]  = '{32'h002080B3, 32'h16, 32'h57, BEU_XNOR, 32'h57, 2'b00, 1'b1};
        vecs[7]  = '{itype({7'b0010100, 5'd5}, 3'b001), 32'h17, 32'h58, BEU_BSET, 32'h5,
                     2'b00, 1'b0};
        // bseti with shamt = 40 (instr[25] set)
        vecs[8]  = '{itype({6'b001010, 6'd40}, 3'b001), 32'h18, 32'h59, BEU_XNOR, 32'h59,
                     2'b00, 1'b1};
        vecs[9]  = '{itype({7'b0110000, 5'd7}, 3'b101), 32'h19, 32'h5A, BEU_ROR, 32'h7,
                     2'b00, 1'b0};
        vecs[10] = '{rtype(7'b0100000, 3'b111), 32'h1A, 32'h5B, BEU_ANDN, 32'h5B, 2'b00, 1'b0};
        vecs[11] = '{rtype(7'b0100100, 3'b101), 32'h1B, 32'h5C, BEU_BEXT, 32'h5C, 2'b00, 1'b0};
        vecs[12] = '{itype(12'h698, 3'b101), 32'h1C, 32'h5D, BEU_MISC, 32'h698, 2'b00, 1'b0};
`ifdef HARDISC_ZBC_EN
        vecs[13] = '{rtype(7'b0000101, 3'b001), 32'h1D, 32'h5E, BEU_CLMUL, 32'h5E, 2'b00, 1'b0};
`else
        vecs[13] = '{rtype(7'b0000101, 3'b001), 32'h1D, 32'h5E, BEU_XNOR, 32'h5E, 2'b00, 1'b1};
`endif
        // clmulh is never supported
        vecs[14] = '{rtype(7'b0000101, 3'b011), 32'h1E, 32'h5F, BEU_XNOR, 32'h5F, 2'b00, 1'b1};
        vecs[15] = '{itype(12'h287, 3'b101), 32'h1F, 32'h60, BEU_MISC, 32'h287, 2'b00, 1'b0};

        resetn  = 1'b0;
        flush   = 1'b0;
        valid_i = 1'b0;
        ready_i = 1'b0;
        instr   = 32'h0;
        rs1     = 32'h0;
        rs2     = 32'h0;
        tick();
        tick();
        chk("reset", pack_out(), pack_exp(1'b0, 1'b1, 1'b0, 2'b00, BEU_SH1ADD, 32'h0, 32'h0));
        resetn = 1'b1;

        // Decode table, one entry at a time with the sink ready
        ready_i = 1'b1;
        for (int i = 0; i < 16; i++) begin
            valid_i = 1'b1;
            instr   = vecs[i].instr;
            rs1     = vecs[i].rs1;
            rs2     = vecs[i].rs2;
            tick();
            valid_i = 1'b0;
            chk($sformatf("vec%0d", i), pack_out(),
                pack_exp(1'b1, 1'b1, vecs[i].ill, vecs[i].cmp, vecs[i].func, vecs[i].rs1,
                         vecs[i].op2));
        end
        tick();
        chk("drain", {95'b0, valid_o}, 96'd0);

        // Full-rate stream
        instr = rtype(7'b0010000, 3'b010);
        for (int k = 0; k < 4; k++) begin
            valid_i = 1'b1;
            rs1     = 32'd10 + k;
            tick();
            chk($sformatf("stream%0d", k), {62'b0, valid_o, ready_o, op1_o},
                {62'b0, 1'b1, 1'b1, 32'd10 + k});
        end
        valid_i = 1'b0;
        tick();

        // Backpressure: three back-to-back entries, sink stalled for four cycles
        sent = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            if (sent < 3) begin
                valid_i = 1'b1;
                rs1     = sent + 1;
            end else begin
                valid_i = 1'b0;
            end
            ready_i = (cyc >= 4);
            if (cyc == 1) chk("bp_ready_after1", {95'b0, ready_o}, 96'd1);
            if (cyc == 2) chk("bp_full", {62'b0, valid_o, ready_o, op1_o}, {62'b0, 2'b10, 32'd1});
            if (cyc == 3) chk("bp_hold", {62'b0, valid_o, ready_o, op1_o}, {62'b0, 2'b10, 32'd1});
            if (valid_o && ready_i) popped.push_back(op1_o);
            if (valid_i && ready_o) sent++;
            tick();
        end
        valid_i = 1'b0;
        chk("bp_count", 96'(popped.size()), 96'd3);
        for (int j = 0; j < 3; j++) begin
            if (j < popped.size()) chk($sformatf("bp_order%0d", j), 96'(popped[j]), 96'(j + 1));
        end

        // Flush while FULL, with a competing input
        ready_i = 1'b0;
        valid_i = 1'b1;
        rs1     = 32'hA1;
        tick();
        rs1 = 32'hA2;
        tick();
        chk("fl_full", {94'b0, valid_o, ready_o}, 96'b10);
        flush = 1'b1;
        rs1   = 32'hA3;
        tick();
        flush   = 1'b0;
        valid_i = 1'b0;
        chk("fl_full_after", {94'b0, valid_o, ready_o}, 96'b01);
        tick();
        chk("fl_full_dropped", {94'b0, valid_o, ready_o}, 96'b01);

        // Flush in ONE state: input is accepted-ready but must still be dropped
        valid_i = 1'b1;
        rs1     = 32'hB1;
        tick();
        flush = 1'b1;
        rs1   = 32'hB2;
        tick();
        flush   = 1'b0;
        valid_i = 1'b0;
        chk("fl_one_after", {94'b0, valid_o, ready_o}, 96'b01);
        tick();
        chk("fl_one_dropped", {94'b0, valid_o, ready_o}, 96'b01);

        // Reset wins over flush and clears a held entry
        valid_i = 1'b1;
        rs1     = 32'hC1;
        tick();
        valid_i = 1'b0;
        resetn  = 1'b0;
        flush   = 1'b1;
        tick();
        chk("rst_prio", pack_out(), pack_exp(1'b0, 1'b1, 1'b0, 2'b00, BEU_SH1ADD, 32'h0, 32'h0));
        resetn = 1'b1;
        flush  = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
